// File: rtl/router_pkg.sv
// Shared constants and width helpers for the 1xN packet router.
// ROUTER_BCAST_EN is handled in the top level; nothing here depends on it.
package router_pkg;

  localparam int ROUTER_DEF_PORTS  = 4;
  localparam int ROUTER_DEF_DATA_W = 8;
  localparam int ROUTER_DEF_DEPTH  = 4;

  function automatic int routerClog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  // One extra bit so the occupancy can represent DEPTH itself.
  function automatic int routerCntW(input int depth);
    return routerClog2(depth) + 1;
  endfunction

endpackage

// File: rtl/router_port_fifo.sv
// First-word-fall-through FIFO for one router output port.
// Used by router_1xn_fifo; ROUTER_BCAST_EN does not affect this block.
module router_port_fifo
  import router_pkg::*;
#(
  parameter  int DATA_W = ROUTER_DEF_DATA_W,
  parameter  int DEPTH  = ROUTER_DEF_DEPTH,
  localparam int PTR_W  = routerClog2(DEPTH),
  localparam int CNT_W  = routerCntW(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q;
  logic [PTR_W-1:0]  rdPtr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              full_q;
  logic              doPush;
  logic              doPop;

  assign doPush = push & ~full_q;
  assign doPop  = pop & (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + 1'b1;
    end else if (doPop && !doPush) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers are exactly PTR_W bits, so they wrap at DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata;
  end

  // Data is masked to zero when empty so no stale word ever shows.
  assign valid = (count_q != '0);
  assign rdata = valid ? mem_q[rdPtr_q] : '0;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/router_1xn_fifo.sv
// 1-to-N packet router with valid/ready handshakes and a FIFO per output.
// Define ROUTER_BCAST_EN to add the bcast input that writes every FIFO at once.
module router_1xn_fifo
  import router_pkg::*;
#(
  parameter  int NUM_PORTS = ROUTER_DEF_PORTS,
  parameter  int DATA_W    = ROUTER_DEF_DATA_W,
  parameter  int DEPTH     = ROUTER_DEF_DEPTH,
  localparam int ADDR_W    = routerClog2(NUM_PORTS),
  localparam int CNT_W     = routerCntW(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pkt_valid,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [ADDR_W-1:0]           dest_addr,
`ifdef ROUTER_BCAST_EN
  input  logic                        bcast,
`endif
  output logic                        ready_in,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic [NUM_PORTS-1:0]        valid_out,
  input  logic [NUM_PORTS-1:0]        ready_out,
  output logic [NUM_PORTS-1:0]        fifo_full,
  output logic                        drop_err
);

  logic                 push;
  logic [NUM_PORTS-1:0] pushVec;
  logic [NUM_PORTS-1:0] popVec;
  logic [CNT_W-1:0]     portCount [NUM_PORTS];
  logic                 stalled_q;
  logic [ADDR_W-1:0]    prevDest_q;
  logic                 dropErr_q;

  // ready_in looks only at registered full flags, so a full FIFO never
  // takes a push in the same cycle it is being popped.
  always_comb begin
    pushVec = '0;
`ifdef ROUTER_BCAST_EN
    ready_in = bcast ? ~|fifo_full : ~fifo_full[dest_addr];
`else
    ready_in = ~fifo_full[dest_addr];
`endif
    push = pkt_valid & ready_in;
    if (push) begin
`ifdef ROUTER_BCAST_EN
      if (bcast) pushVec = '1;
      else       pushVec[dest_addr] = 1'b1;
`else
      pushVec[dest_addr] = 1'b1;
`endif
    end
  end

  assign popVec = valid_out & ready_out;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : gPort
    router_port_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) uFifo (
      .clk  (clk),
      .rst  (rst),
      .push (pushVec[k]),
      .wdata(data_in),
      .pop  (popVec[k]),
      .rdata(data_out[k*DATA_W +: DATA_W]),
      .valid(valid_out[k]),
      .full (fifo_full[k]),
      .count(portCount[k])
    );

    assert property (@(posedge clk) disable iff (rst) portCount[k] <= CNT_W'(DEPTH));
  end

  // A source that was stalled last cycle must present the same destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stalled_q  <= 1'b0;
      prevDest_q <= '0;
      dropErr_q  <= 1'b0;
    end else begin
      stalled_q  <= pkt_valid & ~ready_in;
      prevDest_q <= dest_addr;
      if (stalled_q && pkt_valid && (dest_addr != prevDest_q)) dropErr_q <= 1'b1;
    end
  end

  assign drop_err = dropErr_q;

endmodule

// File: doc/router_1xn_fifo.md
Name: router_1xn_fifo

Overview:
- Parametrised 1-to-N packet router, the successor to the fixed 1x4 router.
- Adds a valid/ready handshake on the input side, per-output valid/ready backpressure, and a per-output FIFO so a stalled output does not block the other outputs.
- Accepts one word per cycle when the target FIFO has space. Sits between the ingress source and N downstream consumers.

Parameters:
- NUM_PORTS, 4, number of output channels; power of two, 2..16.
- DATA_W, 8, payload width in bits.
- DEPTH, 4, entries per output FIFO; power of two, 2..64.
- ADDR_W (localparam), $clog2(NUM_PORTS), destination field width.
- CNT_W (localparam), $clog2(DEPTH)+1, FIFO occupancy width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- pkt_valid  in  1  input word present.
- data_in  in  DATA_W  input payload.
- dest_addr  in  ADDR_W  target output index.
- ready_in  out  1  input accepted this cycle when high together with pkt_valid.
- data_out  out  NUM_PORTS*DATA_W  flat output bus; port k occupies bits [k*DATA_W +: DATA_W].
- valid_out  out  NUM_PORTS  per-port head-of-FIFO valid.
- ready_out  in  NUM_PORTS  per-port consumer ready.
- fifo_full  out  NUM_PORTS  per-port full flag, registered.
- drop_err  out  1  sticky flag; set if pkt_valid is held with a changed dest_addr while stalled.

Behaviour:
- Reset (asynchronous, active-high):
  - All FIFO pointers and counts clear immediately; valid_out=0, fifo_full=0, drop_err=0, data_out=0.
  - ready_in=1 as soon as rst deasserts.
- Push:
  - push = pkt_valid & ready_in.
  - ready_in = ~fifo_full[dest_addr], combinational from the registered full flag and the current dest_addr.
- Pop: pop[k] = valid_out[k] & ready_out[k].
- FIFO type: first-word-fall-through.
  - A word pushed in cycle t is visible as valid_out[k]=1 with its data in cycle t+1; there is no same-cycle bypass.
  - Minimum input-to-output latency is 1 cycle.
- Output data: data_out slice k = head entry when valid_out[k]=1, else 0 (no stale data is visible).
- Simultaneous push and pop on the same port:
  - Count is unchanged; both pointers advance.
  - Allowed when full only if pop is asserted. ready_in is still deasserted in that case, because fifo_full is registered, so a full FIFO accepts no push that cycle; the slot frees for the next cycle.
- Full flag: fifo_full[k] is set when count reaches DEPTH and cleared on the first pop.
- Pointer and count widths:
  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
  - Count is CNT_W bits and never exceeds DEPTH or goes below 0.
- Port independence: a push to port j and a pop from port k≠j are independent in the same cycle; all N ports may pop in one cycle.
- Backpressure rule: when ready_in=0 the source must hold data_in and dest_addr stable. A change in dest_addr while stalled sets drop_err, which stays set until reset; routing itself is unaffected.
- Reset mid-operation: all buffered words are discarded; nothing is output after rst deasserts until a new push.

Optional Feature:
- Macro ROUTER_BCAST_EN.
- Defined:
  - Adds input port bcast (1 bit).
  - A push with bcast=1 writes data_in into every FIFO in the same cycle, ignoring dest_addr.
  - For a bcast word, ready_in = ~|fifo_full (all ports must have space).
  - Each copy is popped independently per port.
- Undefined: no bcast port; unicast only; the logic is removed entirely.

Decomposition:
- Package router_pkg:
  - Helper function to compute ADDR_W/CNT_W.
  - Default parameter constants ROUTER_DEF_PORTS=4, ROUTER_DEF_DATA_W=8, ROUTER_DEF_DEPTH=4.
- Sub-module router_port_fifo (DATA_W, DEPTH):
  - Ports: clk, rst, push, wdata, pop, rdata, valid, full, count.
  - Instantiated NUM_PORTS times by a generate loop.
- Top level contains only the destination decode, ready_in logic, drop_err and the optional broadcast logic.

Test Plan:
- Reset then push 0xA5 to dest 2 with ready_out=4'b1111 -> valid_out=4'b0100 one cycle later, data_out port 2 = 0xA5; popped the next cycle, after which valid_out=0.
- ready_out=0; push 4 words 0x10..0x13 to port 1 -> fifo_full[1]=1 after the 4th push and ready_in=0 for dest 1. A push to dest 0 is still accepted. After releasing ready_out[1], the words drain in order 0x10..0x13.
- Port 3 full, ready_out[3]=1, source holds pkt_valid to dest 3 -> no push in the pop cycle; the push is accepted in the following cycle; count stays ≤4 and never wraps.
- Assert rst asynchronously mid-cycle with 3 words buffered on port 0 -> valid_out=0 and data_out=0 immediately, not at the next edge; no output after release.
- While stalled, change dest_addr from 1 to 2 -> drop_err=1 and stays set until reset.
- With ROUTER_BCAST_EN defined: bcast push of 0x3C with all ready_out=1 -> valid_out=4'b1111 next cycle, all slices =0x3C. With port 0 full, the bcast push is held off (ready_in=0).
